fxp_addsub_pipe: RTL and testbench

Parametrised, pipelined signed fixed-point adder/subtractor. It is the next generation of the single-format adder in the datapath library. It accepts two operands in independent Qm.n formats and adds or subtracts them per transaction. It produces a result in a third, independently chosen format, with selectable rounding, saturate or wrap overflow handling, and valid/ready flow control. Overflow statistics are kept for host readout.

---
 rtl/fxp_pkg.sv | 33 +++
 rtl/fxp_round_sat.sv | 66 ++++++
 rtl/fxp_addsub_pipe.sv | 134 +++++++++++++
 tb/tb_fxp_addsub_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared constants and width helpers for the fixed-point datapath blocks
package fxp_pkg;

  localparam int RND_TRUNC   = 0;
  localparam int RND_HALF_UP = 1;
  localparam int RND_CONV    = 2;

  function automatic int max_i(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  function automatic int calc_iw(input int a_int, input int b_int);
    return max_i(a_int, b_int);
  endfunction

  function automatic int calc_fw(input int a_frac, input int b_frac);
    return max_i(a_frac, b_frac);
  endfunction

  // One guard bit above the common format keeps add/subtract exact.
  function automatic int calc_xw(input int iw, input int fw);
    return iw + fw + 1;
  endfunction

  // Rounding to fewer fraction bits adds one carry bit on top.
  function automatic int calc_rw(input int in_w, input int in_frac, input int out_frac);
    if (out_frac < in_frac)
      return in_w + 1 - (in_frac - out_frac);
    else
      return in_w + (out_frac - in_frac);
  endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// rtl/fxp_round_sat.sv - combinational fraction rounding and integer saturate/wrap
// The two halves are separate paths so a pipeline register may sit between them.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int IN_W     = 10,
  parameter int IN_FRAC  = 5,
  parameter int OUT_INT  = 4,
  parameter int OUT_FRAC = 3,
  parameter int RND_MODE = RND_HALF_UP,
  parameter int SAT_EN   = 1,
  localparam int RW = calc_rw(IN_W, IN_FRAC, OUT_FRAC),
  localparam int OW = OUT_INT + OUT_FRAC
) (
  input  logic [IN_W-1:0] val_i,
  output logic [RW-1:0]   rnd_o,
  input  logic [RW-1:0]   rnd_i,
  output logic [OW-1:0]   sum_o,
  output logic            ovf_o
);

  localparam int R_INT = RW - OUT_FRAC;

  generate
    if (OUT_FRAC < IN_FRAC) begin : g_round
      localparam int D = IN_FRAC - OUT_FRAC;
      logic [IN_W:0] ext;
      logic [IN_W:0] add;
      logic [IN_W:0] tot;

      always_comb begin
        ext = {val_i[IN_W-1], val_i};
        add = '0;
        if (RND_MODE == RND_HALF_UP) begin
          add = (IN_W+1)'(1) << (D - 1);
        end else if (RND_MODE == RND_CONV) begin
          // Ties go to the even neighbour: bias is half minus one plus the kept LSB.
          add = ((IN_W+1)'(1) << (D - 1)) - (IN_W+1)'(1) + (IN_W+1)'(val_i[D]);
        end
        tot = ext + add;
      end

      assign rnd_o = RW'(tot >> D);
    end else begin : g_pad
      assign rnd_o = RW'(val_i) << (OUT_FRAC - IN_FRAC);
    end
  endgenerate

  generate
    if (OUT_INT >= R_INT) begin : g_extend
      assign sum_o = OW'($signed(rnd_i));
      assign ovf_o = 1'b0;
    end else begin : g_reduce
      logic [RW-OW:0] hi;
      logic           neg;
      logic [OW-1:0]  sat_val;

      assign hi      = rnd_i[RW-1:OW-1];
      assign neg     = rnd_i[RW-1];
      assign ovf_o   = ~((&hi) | (~|hi));
      assign sat_val = neg ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
      assign sum_o   = (ovf_o && (SAT_EN != 0)) ? sat_val : rnd_i[OW-1:0];
    end
  endgenerate

endmodule

// File: rtl/fxp_addsub_pipe.sv
// rtl/fxp_addsub_pipe.sv - three-stage signed fixed-point add/subtract with flow control
// and overflow statistics.
module fxp_addsub_pipe
  import fxp_pkg::*;
#(
  parameter int A_INT    = 4,
  parameter int A_FRAC   = 5,
  parameter int B_INT    = 3,
  parameter int B_FRAC   = 5,
  parameter int OUT_INT  = 4,
  parameter int OUT_FRAC = 3,
  parameter int RND_MODE = RND_HALF_UP,
  parameter int SAT_EN   = 1,
  parameter int CNT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [A_INT+A_FRAC-1:0]     a,
  input  logic [B_INT+B_FRAC-1:0]     b,
  input  logic                        sub,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_INT+OUT_FRAC-1:0] sum,
  output logic                        ovf,
  output logic                        ovf_sticky,
  input  logic                        ovf_clr,
  output logic [CNT_W-1:0]            ovf_count
);

  localparam int IW = calc_iw(A_INT, B_INT);
  localparam int FW = calc_fw(A_FRAC, B_FRAC);
  localparam int XW = calc_xw(IW, FW);
  localparam int RW = calc_rw(XW, FW, OUT_FRAC);
  localparam int OW = OUT_INT + OUT_FRAC;

  logic          en;
  logic          v1_q, v2_q, v3_q;
  logic [XW-1:0] a1_d, a1_q;
  logic [XW-1:0] b1_d, b1_q;
  logic          c1_q;
  logic [XW-1:0] exact_d;
  logic [RW-1:0] rnd_d, rnd2_q;
  logic [OW-1:0] sum_d, sum_q;
  logic          ovf_d, ovf_q;
  logic          sticky_d, sticky_q;
  logic [CNT_W-1:0] count_d, count_q;
  logic          xfer_ovf;

  // A held result blocks every stage so nothing is overwritten or lost.
  assign en       = !v3_q || out_ready;
  assign in_ready = en;

  assign a1_d = XW'($signed(a)) <<< (FW - A_FRAC);
  always_comb begin
    b1_d = XW'($signed(b)) <<< (FW - B_FRAC);
    if (sub) b1_d = ~b1_d;
  end

  assign exact_d = a1_q + b1_q + XW'(c1_q);

  fxp_round_sat #(
    .IN_W     (XW),
    .IN_FRAC  (FW),
    .OUT_INT  (OUT_INT),
    .OUT_FRAC (OUT_FRAC),
    .RND_MODE (RND_MODE),
    .SAT_EN   (SAT_EN)
  ) u_round_sat (
    .val_i (exact_d),
    .rnd_o (rnd_d),
    .rnd_i (rnd2_q),
    .sum_o (sum_d),
    .ovf_o (ovf_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      c1_q   <= 1'b0;
      rnd2_q <= '0;
      sum_q  <= '0;
      ovf_q  <= 1'b0;
    end else if (en) begin
      v1_q   <= in_valid;
      a1_q   <= a1_d;
      b1_q   <= b1_d;
      c1_q   <= sub;
      v2_q   <= v1_q;
      rnd2_q <= rnd_d;
      v3_q   <= v2_q;
      sum_q  <= sum_d;
      ovf_q  <= v2_q && ovf_d;
    end
  end

  assign xfer_ovf = v3_q && out_ready && ovf_q;

  // Clear is applied before recording, so a coinciding overflow still counts once.
  always_comb begin
    sticky_d = sticky_q;
    count_d  = count_q;
    if (ovf_clr) begin
      sticky_d = 1'b0;
      count_d  = '0;
    end
    if (xfer_ovf) begin
      sticky_d = 1'b1;
      if (count_d != {CNT_W{1'b1}}) count_d = count_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
      count_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      count_q  <= count_d;
    end
  end

  assign out_valid  = v3_q;
  assign sum        = sum_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;
  assign ovf_count  = count_q;

endmodule

// File: tb/tb_fxp_addsub_pipe.sv
// tb/tb_fxp_addsub_pipe.sv - directed self-checking bench for fxp_addsub_pipe
module tb_fxp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, sub, ovf_clr;
  logic [8:0]  a;
  logic [7:0]  b;

  logic        in_ready, out_valid, ovf, ovf_sticky;
  logic [6:0]  sum;
  logic [15:0] ovf_count;

  logic        w_in_ready, w_out_valid, w_ovf, w_ovf_sticky;
  logic [6:0]  w_sum;
  logic [15:0] w_ovf_count;

  logic        c_in_ready, c_out_valid, c_ovf, c_ovf_sticky;
  logic [6:0]  c_sum;
  logic [15:0] c_ovf_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fxp_addsub_pipe u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr),
    .ovf_count(ovf_count)
  );

  fxp_addsub_pipe #(.SAT_EN(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(w_out_valid), .out_ready(out_ready),
    .sum(w_sum), .ovf(w_ovf), .ovf_sticky(w_ovf_sticky), .ovf_clr(ovf_clr),
    .ovf_count(w_ovf_count)
  );

  fxp_addsub_pipe #(.RND_MODE(2)) u_conv (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(c_out_valid), .out_ready(out_ready),
    .sum(c_sum), .ovf(c_ovf), .ovf_sticky(c_ovf_sticky), .ovf_clr(ovf_clr),
    .ovf_count(c_ovf_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_vec(input logic [8:0] va, input logic [7:0] vb, input logic vs,
                         input string tag);
    int lat;
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    sub      = vs;
    tick();
    in_valid = 1'b0;
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    chk({tag, "_lat"}, lat, 3);
  endtask

  initial begin
    int sent, recv, cyc, seen;
    logic acc, dlv;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clr = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_sticky", ovf_sticky, 0);
    chk("rst_count", ovf_count, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    tick();

    // 1.5 + 0.25
    run_vec(9'h030, 8'h08, 1'b0, "t1");
    chk("t1_sum", sum, 7'h0E);
    chk("t1_ovf", ovf, 0);
    tick();

    // 7.0 + 3.0 overflows
    run_vec(9'h0E0, 8'h60, 1'b0, "t2");
    chk("t2_sum_sat", sum, 7'h3F);
    chk("t2_ovf", ovf, 1);
    chk("t2_sum_wrap", w_sum, 7'h50);
    chk("t2_ovf_wrap", w_ovf, 1);
    tick();
    chk("t2_sticky", ovf_sticky, 1);
    chk("t2_count", ovf_count, 1);

    // -8.0 - 3.0 saturates low
    run_vec(9'h100, 8'h60, 1'b1, "t3a");
    chk("t3a_sum", sum, 7'h40);
    chk("t3a_ovf", ovf, 1);
    chk("t3a_sum_wrap", w_sum, 7'h28);
    tick();
    chk("t3a_count", ovf_count, 2);

    // 0 - (-4.0) is exact
    run_vec(9'h000, 8'h80, 1'b1, "t3b");
    chk("t3b_sum", sum, 7'h20);
    chk("t3b_ovf", ovf, 0);
    tick();

    run_vec(9'h003, 8'h00, 1'b0, "t4a");
    chk("t4a_sum", sum, 7'h01);
    tick();
    run_vec(9'h001, 8'h00, 1'b0, "t4b");
    chk("t4b_sum", sum, 7'h00);
    tick();
    run_vec(9'h002, 8'h00, 1'b0, "t4c");
    chk("t4c_sum", sum, 7'h01);
    chk("t4c_sum_conv", c_sum, 7'h00);
    tick();
    run_vec(9'h1FE, 8'h00, 1'b0, "t4d");
    chk("t4d_sum", sum, 7'h00);
    tick();
    run_vec(9'h006, 8'h00, 1'b0, "t4e");
    chk("t4e_sum_conv", c_sum, 7'h02);
    tick();

    // Eight back-to-back items, result i expected as i; downstream stalls cycles 4..8.
    sent = 0; recv = 0; cyc = 0;
    while (recv < 8 && cyc < 60) begin
      out_ready = !(cyc >= 4 && cyc < 9);
      in_valid  = (sent < 8);
      a         = 9'(sent * 4);
      b         = '0;
      sub       = 1'b0;
      #1;
      if (out_valid) chk("t5_sum", sum, recv);
      if (!out_ready && out_valid) chk("t5_stall_in_ready", in_ready, 0);
      acc = in_valid && in_ready;
      dlv = out_valid && out_ready;
      @(posedge clk);
      #1;
      if (acc) sent++;
      if (dlv) recv++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t5_sent", sent, 8);
    chk("t5_recv", recv, 8);
    #1;
    chk("t5_drained", out_valid, 0);
    tick();

    // Clear coinciding with an overflowed transfer
    run_vec(9'h0E0, 8'h60, 1'b0, "t6");
    chk("t6_ovf", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("t6_count", ovf_count, 1);
    chk("t6_sticky", ovf_sticky, 1);

    // Reset with two results in flight
    in_valid = 1'b1; a = 9'h030; b = 8'h08; sub = 1'b0;
    tick();
    a = 9'h0E0; b = 8'h60;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("t6r_out_valid", out_valid, 0);
    chk("t6r_count", ovf_count, 0);
    chk("t6r_sticky", ovf_sticky, 0);
    rst = 1'b0;
    #1;
    chk("t6r_in_ready", in_ready, 1);
    seen = 0;
    repeat (6) begin
      tick();
      if (out_valid) seen++;
    end
    chk("t6r_no_stale", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
